// File: rtl/cmd_encoder.sv
// Serialises high-level correlator requests into opcode/payload bytes on a valid/ready stream.
// Optional feature macro: CMD_ENCODER_INDEX_CACHE_EN (skip SET_INDEX when the target index is already selected).
module cmd_encoder #(
  parameter int NUM_INPUTS = 4,
  parameter int DELAY_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [3:0]            cmd_index,
  input  logic [DELAY_BITS-1:0] cmd_value,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done,
  output logic                  error
);
  localparam int NIBBLES = DELAY_BITS / 4;

  localparam logic [1:0] OP_DELAY   = 2'd0;
  localparam logic [1:0] OP_LEDS    = 2'd1;
  localparam logic [1:0] OP_BAUD    = 2'd2;

  localparam logic [3:0] OPC_CLEAR          = 4'h0;
  localparam logic [3:0] OPC_SET_INDEX      = 4'h1;
  localparam logic [3:0] OPC_SET_LEDS       = 4'h2;
  localparam logic [3:0] OPC_SET_BAUD       = 4'h3;
  localparam logic [3:0] OPC_SET_DELAY      = 4'h4;
  localparam logic [3:0] OPC_ENABLE_CAPTURE = 4'hD;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  run_q;
  logic                  err_q, err_d;
  logic                  skip_q, skip_d;
  logic                  load;
  logic [1:0]            op_q;
  logic [3:0]            idx_q;
  logic [DELAY_BITS-1:0] val_q;
  logic                  bad_index, hit, last;
  logic [3:0]            pos, len;

  function automatic logic [3:0] seq_len(input logic [1:0] op, input logic skip);
    case (op)
      OP_DELAY: seq_len = 4'(2 + NIBBLES) - {3'b000, skip};
      OP_LEDS:  seq_len = 4'd2 - {3'b000, skip};
      default:  seq_len = 4'd1;
    endcase
  endfunction

  // p is the position in the full (uncached) sequence for this opcode.
  function automatic logic [7:0] enc_byte(input logic [1:0] op, input logic [3:0] p,
                                          input logic [3:0] idx, input logic [DELAY_BITS-1:0] val);
    logic [DELAY_BITS-1:0] sh;
    sh = val >> {p - 4'd2, 2'b00};
    case (op)
      OP_DELAY: begin
        if (p == 4'd0)      enc_byte = {4'h0, OPC_CLEAR};
        else if (p == 4'd1) enc_byte = {idx, OPC_SET_INDEX};
        else                enc_byte = {sh[3:0], OPC_SET_DELAY};
      end
      OP_LEDS: begin
        if (p == 4'd0) enc_byte = {idx, OPC_SET_INDEX};
        else           enc_byte = {2'b00, val[1:0], OPC_SET_LEDS};
      end
      OP_BAUD: enc_byte = {val[3:0], OPC_SET_BAUD};
      default: enc_byte = {3'b000, val[0], OPC_ENABLE_CAPTURE};
    endcase
  endfunction

  assign bad_index = ((cmd_op == OP_DELAY) || (cmd_op == OP_LEDS)) &&
                     ({1'b0, cmd_index} >= 5'(NUM_INPUTS));

  // A skipped SET_INDEX shifts every later byte of the sequence by one slot.
  assign pos  = cnt_q + {3'b000, skip_q && ((op_q == OP_LEDS) || (cnt_q != 4'd0))};
  assign len  = seq_len(op_q, skip_q);
  assign last = (cnt_q == (len - 4'd1));

  assign tx_valid  = (state_q == SEND);
  assign tx_byte   = tx_valid ? enc_byte(op_q, pos, idx_q, val_q) : 8'h00;
  assign cmd_ready = run_q && (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign error     = err_q;

`ifdef CMD_ENCODER_INDEX_CACHE_EN
  logic       cache_vld_q;
  logic [3:0] cache_idx_q;
  logic       idx_sent;

  assign idx_sent = tx_valid && tx_ready && (tx_byte[3:0] == OPC_SET_INDEX);
  assign hit      = cache_vld_q && (cache_idx_q == cmd_index) &&
                    ((cmd_op == OP_DELAY) || (cmd_op == OP_LEDS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cache_vld_q <= 1'b0;
    else if (idx_sent) cache_vld_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (idx_sent) cache_idx_q <= idx_q;
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    skip_d  = skip_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          if (bad_index) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = SEND;
            cnt_d   = 4'd0;
            skip_d  = hit;
          end
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (last) state_d = DONE;
          else      cnt_d   = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      err_q   <= err_d;
      skip_q  <= skip_d;
    end
  end

  // Request payload is only meaningful while SEND, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      op_q  <= cmd_op;
      idx_q <= cmd_index;
      val_q <= cmd_value;
    end
  end
endmodule

// File: tb/tb_cmd_encoder.sv
// Bench for cmd_encoder: constant vector table, hand-written corner sequences and randomized requests
// checked against a queue-based byte-sequence model.
module tb_cmd_encoder;
  localparam int NI = 4;
  localparam int DB = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_index;
  logic [31:0] cmd_value;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  cmd_encoder #(.NUM_INPUTS(NI), .DELAY_BITS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_value(cmd_value),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .done(done), .error(error)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit err_obs;
`ifdef CMD_ENCODER_INDEX_CACHE_EN
  bit         mc_vld;
  logic [3:0] mc_idx;
`endif

  typedef struct {
    logic [1:0]        op;
    logic [3:0]        idx;
    logic [31:0]       val;
    int                mode;
    bit                err;
    int                n;
    logic [0:9][7:0]   b;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Byte sequence from the protocol rules; returns 1 when the request must be rejected.
  function automatic bit model(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] val);
    bit hit = 1'b0;
    exp_q.delete();
    if ((op == 2'd0 || op == 2'd1) && idx >= NI) return 1'b1;
`ifdef CMD_ENCODER_INDEX_CACHE_EN
    hit = mc_vld && (mc_idx == idx);
    if ((op == 2'd0 || op == 2'd1) && !hit) begin
      mc_vld = 1'b1;
      mc_idx = idx;
    end
`endif
    case (op)
      2'd0: begin
        exp_q.push_back(8'h00);
        if (!hit) exp_q.push_back({idx, 4'h1});
        for (int k = 0; k < DB / 4; k++) exp_q.push_back({val[4*k +: 4], 4'h4});
      end
      2'd1: begin
        if (!hit) exp_q.push_back({idx, 4'h1});
        exp_q.push_back({2'b00, val[1:0], 4'h2});
      end
      2'd2:    exp_q.push_back({val[3:0], 4'h3});
      default: exp_q.push_back({3'b000, val[0], 4'hD});
    endcase
    return 1'b0;
  endfunction

  task automatic do_reset;
    cmd_valid = 1'b0;
    tx_ready  = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    step;
    step;
    chk("rst_ready_hold", cmd_ready, 0);
    reset_n = 1'b1;
`ifdef CMD_ENCODER_INDEX_CACHE_EN
    mc_vld = 1'b0;
`endif
    step;
    chk("ready_after_release", cmd_ready, 1);
  endtask

  // mode 0: tx_ready always high, 1: toggling, other: random
  task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] val, input int mode);
    bit rej;
    int wait_n = 0;
    int done_c = -1;
    int hold_bad = 0;
    int busy_bad = 0;
    bit held = 1'b0;
    logic [7:0] hb = 8'h00;
    rej = model(op, idx, val);
    while (!cmd_ready && wait_n < 50) begin
      step;
      wait_n++;
    end
    chk("req_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_index = idx;
    cmd_value = val;
    tx_ready  = 1'b0;
    step;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_index = 4'($urandom);
    cmd_value = $urandom;
    got_q.delete();
    err_obs = error;
    if (rej) begin
      chk("err_pulse", error, 1);
      chk("err_txv", tx_valid, 0);
      chk("err_ready", cmd_ready, 1);
      step;
      chk("err_once", error, 0);
      chk("err_txv2", tx_valid, 0);
      return;
    end
    chk("no_err", error, 0);
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        done_c = c;
        break;
      end
      if (cmd_ready || error || !tx_valid) busy_bad++;
      if (held && (!tx_valid || tx_byte !== hb)) hold_bad++;
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~c[0];
        default: tx_ready = 1'($urandom);
      endcase
      held = 1'b0;
      if (tx_valid && tx_ready) got_q.push_back(tx_byte);
      else if (tx_valid) begin
        held = 1'b1;
        hb   = tx_byte;
      end
      step;
    end
    tx_ready = 1'b0;
    chk("done_seen", longint'(done_c > 0), 1);
    if (mode == 0) chk("done_cycle", done_c, exp_q.size() + 1);
    chk("hold_stable", hold_bad, 0);
    chk("busy_quiet", busy_bad, 0);
    chk("n_bytes", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("byte%0d", k), got_q[k], exp_q[k]);
    chk("done_txv", tx_valid, 0);
    chk("done_rdy", cmd_ready, 0);
    step;
    chk("done_pulse", done, 0);
    chk("rdy_after_done", cmd_ready, 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_index = 4'd0;
    cmd_value = 32'd0;
    tx_ready  = 1'b0;

    tbl[0] = '{2'd0, 4'd2, 32'h000123AB, 0, 1'b0, 10,
               {8'h00, 8'h21, 8'hB4, 8'hA4, 8'h34, 8'h24, 8'h14, 8'h04, 8'h04, 8'h04}};
    tbl[1] = '{2'd1, 4'd3, 32'd2, 1, 1'b0, 2, {8'h31, 8'h22, 64'h0}};
    tbl[2] = '{2'd2, 4'd0, 32'd5, 0, 1'b0, 1, {8'h53, 72'h0}};
    tbl[3] = '{2'd3, 4'd0, 32'd1, 0, 1'b0, 1, {8'h1D, 72'h0}};
    tbl[4] = '{2'd0, 4'd4, 32'h12345678, 0, 1'b1, 0, 80'h0};
    tbl[5] = '{2'd1, 4'd15, 32'd1, 0, 1'b1, 0, 80'h0};
    tbl[6] = '{2'd2, 4'd15, 32'h0000000A, 1, 1'b0, 1, {8'hA3, 72'h0}};
    tbl[7] = '{2'd3, 4'd9, 32'hFFFFFFFE, 0, 1'b0, 1, {8'h0D, 72'h0}};
    tbl[8] = '{2'd0, 4'd0, 32'hFEDCBA98, 2, 1'b0, 10,
               {8'h00, 8'h01, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hD4, 8'hE4, 8'hF4}};
    tbl[9] = '{2'd1, 4'd0, 32'h0000000F, 2, 1'b0, 2, {8'h01, 8'h32, 64'h0}};

    for (int i = 0; i < 10; i++) begin
      do_reset;
      issue(tbl[i].op, tbl[i].idx, tbl[i].val, tbl[i].mode);
      chk($sformatf("tbl%0d_err", i), err_obs, tbl[i].err);
      chk($sformatf("tbl%0d_len", i), got_q.size(), tbl[i].n);
      for (int k = 0; k < tbl[i].n && k < got_q.size(); k++)
        chk($sformatf("tbl%0d_b%0d", i, k), got_q[k], tbl[i].b[k]);
    end

    // Back-to-back single-byte requests at the minimum period.
    do_reset;
    issue(2'd2, 4'd0, 32'd5, 0);
    chk("b2b_first", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h53);
    issue(2'd3, 4'd0, 32'd1, 0);
    chk("b2b_second", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h1D);

    // Reset in the middle of a DELAY sequence, after four bytes.
    do_reset;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_index = 4'd1;
    cmd_value = 32'h12345678;
    step;
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    for (int k = 0; k < 4; k++) step;
    chk("mid_txv_before", tx_valid, 1);
    do_reset;
    issue(2'd2, 4'd0, 32'd0, 0);
    chk("post_rst_len", got_q.size(), 1);
    chk("post_rst_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h03);

`ifdef CMD_ENCODER_INDEX_CACHE_EN
    do_reset;
    issue(2'd1, 4'd1, 32'd0, 0);
    chk("cache_first_len", got_q.size(), 2);
    issue(2'd1, 4'd1, 32'd0, 0);
    chk("cache_hit_len", got_q.size(), 1);
    chk("cache_hit_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h02);
    do_reset;
    issue(2'd1, 4'd1, 32'd0, 0);
    chk("cache_rst_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h11);
`endif

    do_reset;
    for (int r = 0; r < 60; r++) begin
      logic [3:0] ridx;
      ridx = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      issue(2'($urandom_range(0, 3)), ridx, $urandom, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cmd_encoder.md
# cmd_encoder

Host-side command encoder for the correlator's UART control protocol. It accepts one high-level request per handshake (set delay, set LEDs, set baud rate, enable capture) and serialises it into the byte sequence the correlator command decoder expects. Each byte carries a 4-bit opcode in [3:0] and a payload in [7:4]. Bytes are delivered over a valid/ready byte stream to a UART transmitter. The block is the initiator for the correlator's command receiver.

## Interface
- NUM_INPUTS, 4, number of correlator inputs; valid cmd_index range is 0..NUM_INPUTS-1 (max 16)
- DELAY_BITS, 32, width of delay value; must be a multiple of 4

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  encoder can accept a request
- cmd_op  in  2  0=DELAY, 1=LEDS, 2=BAUD, 3=CAPTURE
- cmd_index  in  4  target input / LED pair index
- cmd_value  in  DELAY_BITS  payload value
- tx_byte  out  8  encoded byte
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  UART transmitter accepts byte
- done  out  1  one-cycle pulse after the last byte of a request is accepted
- error  out  1  one-cycle pulse when a request is rejected

## Operation
- Opcodes: CLEAR=0, SET_INDEX=1, SET_LEDS=2, SET_BAUD_RATE=3, SET_DELAY=4, ENABLE_CAPTURE=13.
- DELAY emits 2+DELAY_BITS/4 bytes (10 at default):
  - 0x00 (CLEAR)
  - {cmd_index,4'h1}
  - {nibble_k,4'h4} for k=0..DELAY_BITS/4-1, least-significant nibble first
- LEDS emits 2 bytes: {cmd_index,4'h1}, then {2'b00,cmd_value[1:0],4'h2}.
- BAUD emits 1 byte: {cmd_value[3:0],4'h3}.
- CAPTURE emits 1 byte: {3'b000,cmd_value[0],4'hD}.
- DELAY or LEDS with cmd_index >= NUM_INPUTS is rejected:
  - error pulses for one cycle; no bytes are emitted; state stays IDLE.
  - BAUD and CAPTURE ignore cmd_index.
- cmd_op, cmd_index and cmd_value are captured into internal registers at acceptance. Input changes after acceptance have no effect.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, either accept (go to SEND, byte counter=0, present first byte) or reject (stay IDLE).
  - SEND: tx_valid=1. On tx_ready, advance the counter. If that was the last byte, go to DONE; otherwise present the next byte.
  - DONE: done=1 for one cycle, then go to IDLE.
- Byte counter is 4 bits wide. It never wraps, because the maximum sequence is 10 bytes at default.

## Timing
- Reset values: cmd_ready=0 while reset_n is low and 1 after release; tx_valid=0; tx_byte=0x00; done=0; error=0; FSM=IDLE.
- Accept cycle is cmd_valid & cmd_ready. tx_valid rises on the following edge with the first byte.
- tx_byte is held stable while tx_valid=1 && tx_ready=0.
- With tx_ready held high, one byte is transferred per cycle and tx_valid stays high across bytes.
- After the last byte is accepted:
  - tx_valid=0 and done=1 on the next cycle.
  - cmd_ready=1 on the cycle after that.
- Minimum request period is N+2 cycles for an N-byte sequence.
- error asserts on the cycle after the rejected request is sampled. cmd_ready stays 1.
- Reset asserted mid-sequence aborts immediately to reset values. The partial sequence is not resumed.

## Configuration
- CMD_ENCODER_INDEX_CACHE_EN:
  - Defined: the encoder keeps the last SET_INDEX value sent plus a valid flag. The flag is cleared by reset and set when a SET_INDEX byte is accepted. If a DELAY or LEDS request targets the cached index, the SET_INDEX byte is omitted: DELAY is 9 bytes (CLEAR then nibbles), LEDS is 1 byte.
  - Undefined: SET_INDEX is always emitted and no cache exists.

## Test plan
- DELAY, index 2, value 0x0001_23AB, tx_ready=1 -> tx_byte sequence 0x00,0x21,0xB4,0xA4,0x34,0x24,0x14,0x04,0x04,0x04; done on cycle 11 after accept.
- LEDS, index 3, value 2, with tx_ready toggled every other cycle -> 0x31 then 0x22; each byte held stable until accepted; exactly 2 transfers.
- BAUD value 5, then CAPTURE value 1, issued back-to-back -> 0x53, then 0x1D; second cmd_ready rises 2 cycles after the first byte is accepted.
- DELAY with index 4 (NUM_INPUTS=4) -> error pulse, tx_valid stays 0, cmd_ready stays 1.
- Reset asserted after the 4th byte of a DELAY -> tx_valid=0 at once; after release a new BAUD value 0 request yields a single byte 0x03.
- With CMD_ENCODER_INDEX_CACHE_EN: LEDS index 1 twice -> first request 0x11,0x02 (value 0), second request 0x02 only; after reset the same request again emits 0x11 first.
